friscv_scfifo_reader: RTL and testbench

- Single-clock FIFO controller built around the shared write-port / async-read-port RAM.
- Owns write and read pointers, full/empty flags and occupancy. Drains the RAM into a registered output stage with a valid/ready handshake.
- The output stage is first-word-fall-through (FWFT), so downstream logic (instruction fetch buffers, AXI response queues) sees a registered data path.
- Capacity is 2**ADDR_WIDTH RAM entries plus 1 output-stage entry.

---
 rtl/friscv_scfifo_reader_pkg.sv | 8 +
 rtl/friscv_scfifo_ram.sv | 28 ++
 rtl/friscv_scfifo_reader.sv | 106 ++++++++++
 tb/tb_friscv_scfifo_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_scfifo_reader_pkg.sv
// Shared defaults for the single-clock FIFO reader and its storage RAM.
// Widths stay local to each module; only default sizes live here.
package friscv_scfifo_reader_pkg;

   localparam int SCFIFO_ADDR_WIDTH_DEFAULT = 8;
   localparam int SCFIFO_DATA_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/friscv_scfifo_ram.sv
// Storage for the FIFO: one synchronous write port, one asynchronous read port.
// Depth is 2**ADDR_WIDTH words.
module friscv_scfifo_ram
   import friscv_scfifo_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = SCFIFO_ADDR_WIDTH_DEFAULT,
   parameter int DATA_WIDTH = SCFIFO_DATA_WIDTH_DEFAULT
) (
   input  logic                  aclk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] addr_out,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // NOTE: payload storage has no reset; the pointers alone define which words are valid.
   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[addr_in] <= data_in;
      end
   end

   assign data_out = mem[addr_out];

endmodule

// File: rtl/friscv_scfifo_reader.sv
// Single-clock FIFO controller: pointers, flags, occupancy and a registered
// first-word-fall-through output stage in front of friscv_scfifo_ram.
module friscv_scfifo_reader
   import friscv_scfifo_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = SCFIFO_ADDR_WIDTH_DEFAULT,
   parameter int DATA_WIDTH = SCFIFO_DATA_WIDTH_DEFAULT
) (
   input  logic                  aclk,
   input  logic                  srst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  ram_full,
   output logic                  ram_empty,
   output logic [ADDR_WIDTH+1:0] level
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam int LW = ADDR_WIDTH + 2;

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [LW-1:0]         level_q, level_d;
   logic [PW-1:0]         occ_d;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  push;
   logic                  load;

   assign ram_empty = (wr_ptr_q == rd_ptr_q);
   assign ram_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
   assign in_ready  = !ram_full;

   // A flush or reset cycle drops any handshake, so the RAM write is masked too.
   assign push = in_valid && in_ready && !flush && !srst;
   assign load = !ram_empty && (!out_valid_q || out_ready);

   friscv_scfifo_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .aclk     (aclk),
      .wr_en    (push),
      .addr_in  (wr_ptr_q[ADDR_WIDTH-1:0]),
      .data_in  (in_data),
      .addr_out (rd_ptr_q[ADDR_WIDTH-1:0]),
      .data_out (ram_rdata)
   );

   // NOTE: every next-state signal gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (load) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            out_valid_d = 1'b1;
            out_data_d  = ram_rdata;
         end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
      end
      // Occupancy is taken modulo 2**PW before widening to the level width.
      occ_d   = wr_ptr_d - rd_ptr_d;
      level_d = {1'b0, occ_d} + {{(LW-1){1'b0}}, out_valid_d};
   end

   // NOTE: state registers use non-blocking assignments so all of them update together.
   always_ff @(posedge aclk) begin
      if (srst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         level_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         level_q     <= level_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign level     = level_q;

endmodule

// File: tb/tb_friscv_scfifo_reader.sv
// Self-checking bench for friscv_scfifo_reader (ADDR_WIDTH=2): directed steps
// plus random backpressure, checked against a word scoreboard and a cycle model.
module tb_friscv_scfifo_reader;

   localparam int AW    = 2;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          aclk      = 1'b0;
   logic          srst      = 1'b1;
   logic          flush     = 1'b0;
   logic          in_valid  = 1'b0;
   logic [DW-1:0] in_data   = '0;
   logic          out_ready = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          ram_full;
   logic          ram_empty;
   logic [AW+1:0] level;

   friscv_scfifo_reader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .aclk      (aclk),
      .srst      (srst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .ram_full  (ram_full),
      .ram_empty (ram_empty),
      .level     (level)
   );

   always #5 aclk = ~aclk;

   int            checks     = 0;
   int            failures   = 0;
   logic [DW-1:0] sb[$];
   int            r          = 0;
   bit            ov         = 1'b0;
   int            cyc        = 0;
   int            fires      = 0;
   int            first_fire = -1;
   int            last_fire  = -1;
   bit            hold_prev  = 1'b0;
   logic [DW-1:0] hold_data  = '0;
   bit            pushed     = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: compare DUT against the model, retire/queue words, advance the model.
   task automatic tick();
      logic [DW-1:0] exp_d;
      bit            do_push;
      bit            do_load;
      check("in_ready", in_ready, r != DEPTH);
      check("out_valid", out_valid, ov);
      check("ram_empty", ram_empty, r == 0);
      check("ram_full", ram_full, r == DEPTH);
      check("level", level, r + int'(ov));
      if (hold_prev) check("out_data_stable", out_data, hold_data);
      if (ov && out_ready) begin
         if (sb.size() > 0) begin
            exp_d = sb.pop_front();
            check("out_data", out_data, exp_d);
         end else begin
            check("scoreboard_underflow", sb.size(), 1);
         end
         fires++;
         if (first_fire < 0) first_fire = cyc;
         last_fire = cyc;
      end
      hold_prev = ov && !out_ready;
      hold_data = out_data;
      do_push   = in_valid && (r != DEPTH) && !srst && !flush;
      do_load   = (r > 0) && (!ov || out_ready);
      if (srst || flush) begin
         sb.delete();
         r         = 0;
         ov        = 1'b0;
         hold_prev = 1'b0;
      end else begin
         if (do_push) sb.push_back(in_data);
         r = r + int'(do_push) - int'(do_load);
         if (do_load) ov = 1'b1;
         else if (ov && out_ready) ov = 1'b0;
      end
      pushed = do_push;
      @(posedge aclk);
      #1;
      cyc++;
   endtask

   task automatic clear_test(input bit use_srst);
      int f0;
      string m;
      m = use_srst ? "srst" : "flush";
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'h31 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      check({m, "_pre_level"}, level, 3);
      f0 = fires;
      if (use_srst) srst = 1'b1;
      else flush = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hEE;
      out_ready = 1'b1;
      tick();
      srst     = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      f0       = fires;
      check({m, "_level"}, level, 0);
      check({m, "_out_valid"}, out_valid, 0);
      check({m, "_out_data"}, out_data, 0);
      repeat (4) tick();
      check({m, "_no_delivery"}, fires - f0, 0);
   endtask

   initial begin
      int sent;
      // Reset then idle.
      repeat (2) @(posedge aclk);
      #1;
      srst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_ram_empty", ram_empty, 1);
      check("rst_ram_full", ram_full, 0);
      check("rst_level", level, 0);
      check("rst_out_data", out_data, 0);
      tick();

      // Single word latency.
      in_valid = 1'b1;
      in_data  = 8'hA1;
      tick();
      in_valid = 1'b0;
      check("a1_not_yet_valid", out_valid, 0);
      tick();
      check("a1_out_valid", out_valid, 1);
      check("a1_out_data", out_data, 8'hA1);
      check("a1_level", level, 1);
      check("a1_ram_empty", ram_empty, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();

      // Fill to capacity with the consumer stalled.
      in_valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         in_data = 8'(i);
         tick();
      end
      in_data = 8'h06;
      tick();
      tick();
      check("fill_ram_full", ram_full, 1);
      check("fill_in_ready", in_ready, 0);
      check("fill_level", level, 5);
      check("fill_head", out_data, 8'h01);
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (pushed) break;
      end
      in_valid = 1'b0;
      check("fill_06_accepted", pushed, 1);
      repeat (8) tick();
      check("fill_drained", sb.size(), 0);

      // Continuous streaming, pointers wrap several times.
      fires      = 0;
      first_fire = -1;
      last_fire  = -1;
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(i);
         tick();
      end
      in_valid = 1'b0;
      repeat (4) tick();
      check("stream_count", fires, 16);
      check("stream_no_gaps", last_fire - first_fire, 15);

      // Random backpressure on both sides.
      sent = 0;
      for (int c = 0; c < 20000 && sent < 1000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
         if (pushed) sent++;
      end
      check("rand_sent", sent, 1000);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) tick();
      check("rand_drained", sb.size(), 0);

      // Flush and reset with words queued and a handshake in the same cycle.
      clear_test(1'b0);
      clear_test(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
